present_encrypt_ctrl: RTL and testbench
=======================================

# present_encrypt_ctrl

Transaction controller that sits directly upstream and downstream of the PRESENT-80 encryption core. It accepts a plaintext/key pair over a valid/ready handshake and issues the core's single-cycle load. It then waits for the core's done indication, captures the ciphertext one cycle later and returns it over a second valid/ready handshake. It also drives a measurement trigger that spans exactly the core's active rounds, for the on-chip sensor (RPA) capture logic.

## Interface
- TIMEOUT, 48: max RUN-state cycles without core_done before abort; must be ≥ 32.
- CNT_W, 16: width of completed-encryption counter.

- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  plaintext/key pair offered.
- in_ready  out  1  controller can accept (high only in IDLE).
- in_pt  in  64  plaintext.
- in_key  in  80  key.
- out_valid  out  1  ciphertext available.
- out_ready  in  1  consumer accepts ciphertext.
- out_ct  out  64  ciphertext.
- core_idat  out  64  to core data input (registered copy of in_pt).
- core_key  out  80  to core key input (registered copy of in_key).
- core_load  out  1  to core load; one-cycle pulse.
- core_odat  in  64  from core ciphertext output.
- core_done  in  1  from core done flag.
- trigger  out  1  high while the core is encrypting.
- err  out  1  sticky timeout flag; cleared only by rst.
- enc_count  out  CNT_W  number of ciphertexts delivered; wraps.

## Operation
- States: IDLE, LOAD, RUN, CAPTURE, OUT.
- IDLE: in_ready=1. On in_valid&in_ready, register in_pt→core_idat and in_key→core_key, then go to LOAD.
- LOAD: core_load=1 for exactly this cycle, then go to RUN. Clear the watchdog counter.
- RUN: watchdog counter increments each cycle.
  - core_done=1 → CAPTURE.
  - Counter reaches TIMEOUT without done → set err, go to IDLE, no output produced.
  - core_done is sampled only in RUN. The core's done re-pulses every 32 cycles as its round counter free-runs, and those pulses are ignored in other states.
- CAPTURE: core_odat now holds the new ciphertext (the core registers it on the edge that ends its done cycle). Latch core_odat→out_ct, then go to OUT.
- OUT: out_valid=1 and out_ct is stable.
  - On out_ready → IDLE, enc_count+1 (modulo 2^CNT_W).
  - out_ready may be held low indefinitely; data is held with no loss.
- trigger=1 in LOAD, RUN and CAPTURE; 0 in IDLE and OUT.
- core_idat and core_key hold their values until the next accept. The core has no reset, so the controller must never assert core_load outside LOAD.
- No new input is accepted until the output handshake completes (one transaction in flight).

## Timing
- Reset values:
  - state=IDLE.
  - in_ready=1, out_valid=0, core_load=0, trigger=0, err=0.
  - out_ct=0, core_idat=0, core_key=0, enc_count=0.
- Let edge 0 be the accept edge.
  - LOAD occupies the cycle after edge 0.
  - Core round=1 after edge 1.
  - core_done is high after edge 31, giving 31 RUN cycles.
  - CAPTURE follows edge 32.
  - out_valid=1 after edge 33.
- Latency: 33 cycles from accept to out_valid. trigger is high for 33 cycles.
- Minimum period per transaction is 35 cycles: accept, 33 cycles of processing, then the output handshake with out_ready held high, then back to IDLE.
- The output handshake and the next input acceptance never occur in the same cycle. IDLE is entered first.
- rst during any state (including mid-RUN) → IDLE immediately.
  - Outputs return to reset values and the in-flight result is discarded.
  - The core keeps cycling harmlessly.
- in_valid deasserting in IDLE before acceptance has no effect. Inputs are sampled only on the accept edge.

## Test plan
- pt=0000000000000000, key=0 → out_ct=5579c1387b228445, out_valid first high 33 cycles after accept, enc_count=1.
- Back-to-back vectors with out_ready=1:
  - pt=0, key=all-F → e72c46c0f5945049.
  - pt=all-F, key=0 → a112ffc72f68417b.
  - pt=all-F, key=all-F → 3333dcd3213210d2.
  - Required: each exactly 35 cycles apart, enc_count=3.
- Backpressure: hold out_ready=0 for 100 cycles in OUT → out_ct stable, in_ready=0, core_load never pulses; release → IDLE, one count added.
- Core done tied 0 → err=1 after TIMEOUT(48) RUN cycles, return to IDLE, out_valid never asserts, err persists across subsequent good transactions.
- Assert rst at RUN cycle 15 → all outputs at reset values. The next transaction (pt=0, key=0) still yields 5579c1387b228445.
- trigger check: high exactly for cycles LOAD..CAPTURE (33 cycles), core_load high exactly 1 cycle per transaction.

Source files
------------

// File: rtl/present_encrypt_ctrl.sv
`default_nettype none
// ============================================================================
// present_encrypt_ctrl : handshake front/back end and RPA trigger for PRESENT-80
// Rev 1.0
// ============================================================================
module present_encrypt_ctrl #(
    parameter int TIMEOUT = 48,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_pt,
    input  logic [79:0]      in_key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_ct,
    output logic [63:0]      core_idat,
    output logic [79:0]      core_key,
    output logic             core_load,
    input  logic [63:0]      core_odat,
    input  logic             core_done,
    output logic             trigger,
    output logic             err,
    output logic [CNT_W-1:0] enc_count
);

    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_RUN     = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_OUT     = 3'd4;

    logic [2:0]      state;
    logic [2:0]      next_state;
    logic [WD_W-1:0] wd_cnt;
    logic            accept;
    logic            timeout;

    assign accept  = in_valid && in_ready;
    assign timeout = (state == S_RUN) && (wd_cnt == WD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // core_done is only meaningful in RUN; its free-running re-pulses elsewhere are ignored
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    if (in_valid) next_state = S_LOAD;
            S_LOAD:    next_state = S_RUN;
            S_RUN: begin
                if (core_done)    next_state = S_CAPTURE;
                else if (timeout) next_state = S_IDLE;
            end
            S_CAPTURE: next_state = S_OUT;
            S_OUT:     if (out_ready) next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        core_load = 1'b0;
        trigger   = 1'b0;
        case (state)
            S_IDLE:    in_ready  = 1'b1;
            S_LOAD: begin
                core_load = 1'b1;
                trigger   = 1'b1;
            end
            S_RUN:     trigger   = 1'b1;
            S_CAPTURE: trigger   = 1'b1;
            S_OUT:     out_valid = 1'b1;
            default:   in_ready  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_idat <= '0;
            core_key  <= '0;
            out_ct    <= '0;
            wd_cnt    <= '0;
            err       <= 1'b0;
            enc_count <= '0;
        end else begin
            if (accept) begin
                core_idat <= in_pt;
                core_key  <= in_key;
            end
            if (state == S_LOAD) begin
                wd_cnt <= '0;
            end else if (state == S_RUN) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
            if (timeout && !core_done) begin
                err <= 1'b1;
            end
            // the core updates its output on the edge ending its done cycle
            if (state == S_CAPTURE) begin
                out_ct <= core_odat;
            end
            if ((state == S_OUT) && out_ready) begin
                enc_count <= enc_count + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_present_encrypt_ctrl.sv
`default_nettype none
// ============================================================================
// tb_present_encrypt_ctrl : bench with a PRESENT-80 core model and scoreboard
// Rev 1.0
// ============================================================================
module tb_present_encrypt_ctrl;

    localparam int TIMEOUT = 48;
    localparam int CNT_W   = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_pt;
    logic [79:0]      in_key;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_ct;
    logic [63:0]      core_idat;
    logic [79:0]      core_key;
    logic             core_load;
    logic [63:0]      core_odat = '0;
    logic             core_done;
    logic             trigger;
    logic             err;
    logic [CNT_W-1:0] enc_count;

    always #5 clk = ~clk;

    present_encrypt_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_pt(in_pt), .in_key(in_key),
        .out_valid(out_valid), .out_ready(out_ready), .out_ct(out_ct),
        .core_idat(core_idat), .core_key(core_key), .core_load(core_load),
        .core_odat(core_odat), .core_done(core_done),
        .trigger(trigger), .err(err), .enc_count(enc_count)
    );

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [63:0] tbl;
        tbl = 64'h2174_8FE3_DA09_B65C;
        return tbl[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [63:0] present80(input logic [63:0] pt, input logic [79:0] key);
        logic [63:0] s;
        logic [63:0] t;
        logic [79:0] k;
        s = pt;
        k = key;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ k[79:16];
            for (int i = 0; i < 16; i++) s[4*i +: 4] = sbox(s[4*i +: 4]);
            t = '0;
            for (int i = 0; i < 63; i++) t[(i*16) % 63] = s[i];
            t[63] = s[63];
            s = t;
            k = {k[18:0], k[79:19]};
            k[79:76] = sbox(k[79:76]);
            k[19:15] = k[19:15] ^ 5'(r);
        end
        return s ^ k[79:16];
    endfunction

    // Core model: free-running 5-bit round counter, done at round 31, result on the next edge
    logic [4:0]  core_round = '0;
    logic [63:0] core_pend  = '0;
    logic        done_tie0  = 1'b0;
    always @(posedge clk) begin
        if (core_load) begin
            core_round <= 5'd1;
            core_pend  <= present80(core_idat, core_key);
        end else begin
            core_round <= core_round + 5'd1;
        end
        if (core_round == 5'd31) core_odat <= core_pend;
    end
    assign core_done = (core_round == 5'd31) && !done_tie0;

    int cyc = 0, acc_cyc = 0, trig_cnt = 0, load_cnt = 0, overlap = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (in_valid && in_ready) acc_cyc <= cyc;
        if (trigger) trig_cnt <= trig_cnt + 1;
        if (core_load) load_cnt <= load_cnt + 1;
        if (in_ready && (out_valid || core_load || trigger)) overlap <= overlap + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;
    int exp_cnt = 0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_txn(input logic [63:0] pt, input logic [79:0] key, input int hold,
                          input logic [63:0] exp_ct, input string tag);
        int lat;
        int t0;
        int l0;
        bit busy_ok;
        bit hold_ok;
        lat = 0;
        while (!in_ready && lat < 100) begin tick; lat++; end
        in_valid = 1'b1; in_pt = pt; in_key = key;
        tick;
        in_valid = 1'b0;
        in_pt  = {$urandom, $urandom};
        in_key = {$urandom, $urandom, 16'($urandom)};
        t0 = trig_cnt; l0 = load_cnt; lat = 0; busy_ok = 1'b1;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_ok = 1'b0;
            tick;
            lat++;
        end
        chk({tag, "_latency"}, 80'(lat), 80'd33);
        chk({tag, "_ct"}, {16'd0, out_ct}, {16'd0, exp_ct});
        chk({tag, "_trigger_cycles"}, 80'(trig_cnt - t0), 80'd33);
        chk({tag, "_busy"}, {79'd0, busy_ok}, 80'd1);
        hold_ok = 1'b1;
        repeat (hold) begin
            tick;
            if (!out_valid || out_ct !== exp_ct || in_ready) hold_ok = 1'b0;
        end
        chk({tag, "_hold"}, {79'd0, hold_ok}, 80'd1);
        chk({tag, "_load_pulses"}, 80'(load_cnt - l0), 80'd1);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        exp_cnt++;
        chk({tag, "_handshake"}, {78'd0, out_valid, in_ready}, 80'b01);
        chk({tag, "_count"}, {64'd0, enc_count}, 80'(16'(exp_cnt)));
    endtask

    typedef struct {
        logic [63:0] pt;
        logic [79:0] key;
        logic [63:0] ct;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int acc_prev;
        int lat;
        int t0;
        bit seen;
        logic [63:0] rpt;
        logic [79:0] rkey;

        vecs[0] = '{64'h0, 80'h0, 64'h5579c1387b228445};
        vecs[1] = '{64'h0, {80{1'b1}}, 64'he72c46c0f5945049};
        vecs[2] = '{{64{1'b1}}, 80'h0, 64'ha112ffc72f68417b};
        vecs[3] = '{{64{1'b1}}, {80{1'b1}}, 64'h3333dcd3213210d2};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_pt = '0; in_key = '0;
        repeat (3) tick;
        chk("reset_ctrl", {75'd0, in_ready, out_valid, core_load, trigger, err}, 80'b10000);
        rst = 1'b0;
        chk("reset_data", {16'd0, out_ct | core_idat}, 80'd0);
        chk("reset_key_cnt", core_key | {64'd0, enc_count}, 80'd0);

        // in_valid pulses that go away in IDLE must not matter; the accepted pair is what counts
        in_pt = {$urandom, $urandom};
        tick;
        chk("idle_no_valid", {79'd0, in_ready}, 80'd1);

        acc_prev = 0;
        for (int i = 0; i < 4; i++) begin
            do_txn(vecs[i].pt, vecs[i].key, 0, vecs[i].ct, $sformatf("vec%0d", i));
            if (i > 0) chk($sformatf("vec%0d_spacing", i), 80'(acc_cyc - acc_prev), 80'd35);
            acc_prev = acc_cyc;
        end

        rpt = {$urandom, $urandom}; rkey = {$urandom, $urandom, 16'($urandom)};
        do_txn(rpt, rkey, 100, present80(rpt, rkey), "backpressure");

        done_tie0 = 1'b1;
        in_valid = 1'b1; in_pt = {$urandom, $urandom};
        tick;
        in_valid = 1'b0;
        t0 = trig_cnt; lat = 0; seen = 1'b0;
        while (!in_ready && lat < 200) begin
            if (out_valid) seen = 1'b1;
            tick;
            lat++;
        end
        chk("timeout_cycles", 80'(lat), 80'(TIMEOUT + 1));
        chk("timeout_err", {79'd0, err}, 80'd1);
        chk("timeout_no_out", {79'd0, seen}, 80'd0);
        chk("timeout_trigger", 80'(trig_cnt - t0), 80'(TIMEOUT + 1));
        chk("timeout_count", {64'd0, enc_count}, 80'(16'(exp_cnt)));
        done_tie0 = 1'b0;

        rpt = {$urandom, $urandom}; rkey = {$urandom, $urandom, 16'($urandom)};
        do_txn(rpt, rkey, 2, present80(rpt, rkey), "after_timeout");
        chk("err_sticky", {79'd0, err}, 80'd1);

        in_valid = 1'b1; in_pt = {$urandom, $urandom} | 64'h1; in_key = {$urandom, $urandom, 16'($urandom)} | 80'h1;
        tick;
        in_valid = 1'b0;
        repeat (15) tick;
        chk("midrun_trigger", {79'd0, trigger}, 80'd1);
        rst = 1'b1;
        #1;
        chk("midrun_rst_ctrl", {75'd0, in_ready, out_valid, core_load, trigger, err}, 80'b10000);
        chk("midrun_rst_data", {16'd0, out_ct | core_idat}, 80'd0);
        chk("midrun_rst_key_cnt", core_key | {64'd0, enc_count}, 80'd0);
        tick;
        rst = 1'b0;
        exp_cnt = 0;
        do_txn(64'h0, 80'h0, 0, 64'h5579c1387b228445, "post_reset");

        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 3)) tick;
            rpt = {$urandom, $urandom}; rkey = {$urandom, $urandom, 16'($urandom)};
            do_txn(rpt, rkey, $urandom_range(0, 6), present80(rpt, rkey), $sformatf("rnd%0d", i));
        end

        chk("in_ready_exclusive", 80'(overlap), 80'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got stuck expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
